contador_cm_param: RTL
======================

// Module: contador_cm_param
// PURPOSE
//  Parametrised pulse-width-to-distance converter for the ultrasonic sensor path.
//  Measures the width of the echo pulse in clock cycles and converts it to whole centimetres.
//  The result is a DIGITOS-digit BCD value, with optional half-cm rounding, saturation and an overflow flag.
//  Datapath (cm tick divider, BCD counter) and FSM are integrated; sits between echo synchroniser and display/serial logic.
// PARAMETERS
//  DIGITOS    3     number of BCD digits in result (1..6)
//  TICKS_CM   2941  clock cycles per cm (50 MHz: 58.82 us/cm); >= 2
//  TICK_W     12    width of internal tick counter; 2**TICK_W > TICKS_CM
//  ARREDONDA  1     1: round residual >= TICKS_CM/2 (integer div) up by 1 cm; 0: truncate
// PORTS
//  clock      in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-low; 0 clears all state immediately
//  pulso      in   1          echo pulse, already synchronised to clock
//  medida     out  4*DIGITOS  BCD result, digit 0 in [3:0]; held until next measurement starts
//  pronto     out  1          1-cycle pulse: medida valid
//  ocupado    out  1          1 while a measurement is in progress (MEDE, ARRED)
//  overflow   out  1          result saturated at all-9s; sticky until next start
//  db_estado  out  3          current FSM state code, debug
// BEHAVIOUR
//  Reset (reset=0, async): state INICIAL, medida=0, pronto=0, ocupado=0, overflow=0, tick counter=0, pulso_d=0.
//  Edge detect: pulso_d registers pulso every cycle; subida = pulso & ~pulso_d.
//  States (db_estado): INICIAL=000, MEDE=001, ARRED=010, FIM=011.
//  INICIAL: outputs held. On an edge with subida=1: go to MEDE, clear BCD and overflow, set tick counter=1.
//    That edge counts as the first high sample. A pulso stuck high never starts a measurement.
//  MEDE: ocupado=1. On each edge with pulso=1, tick counter increments.
//    If tick counter == TICKS_CM-1 at that edge: tick counter wraps to 0 and BCD +1 on the same edge.
//    On an edge with pulso=0: go to ARRED if ARREDONDA=1, else FIM. Tick counter holds the residual.
//  ARRED: ocupado=1, one cycle. If residual >= TICKS_CM/2: BCD +1. Go to FIM.
//  FIM: pronto=1 for exactly one cycle, ocupado=0. Always returns to INICIAL.
//    A subida during FIM is ignored; a new pulse must rise while in INICIAL.
//  Result: N = number of high samples counted.
//    medida = floor(N/TICKS_CM), + 1 when rounding applies.
//    Residual 0 never rounds up.
//  BCD counter: per-digit 9->0 carry. All-9s + increment: value holds at all-9s and overflow is set.
//    Applies in both MEDE and ARRED.
//  Latency: pulso sampled low at edge k; pronto high in cycle k+2 (ARREDONDA=1) or k+1 (ARREDONDA=0).
//  Reset mid-measurement: immediate return to INICIAL with medida=0; no pronto is issued.
//  medida changes only while ocupado=1. Consumers latch it on pronto.
// TESTING (bench: TICKS_CM=4, DIGITOS=2 unless noted)
//  1 reset=0 then 1, pulso=0 -> medida=00, pronto=0, ocupado=0, db_estado=000.
//  2 ARREDONDA=1, pulso high 10 cycles -> medida=03, one pronto pulse 2 cycles after fall.
//    Same test, 9 cycles -> 02.
//  3 ARREDONDA=0, pulso high 10 cycles -> 02; high 8 cycles -> 02 (residual 0, no round).
//    pronto arrives 1 cycle after fall.
//  4 pulso high 420 cycles -> medida=99, overflow=1. Next 4-cycle pulse -> medida=01, overflow=0.
//  5 pulso high 6 cycles, reset=0 pulsed at cycle 3 -> medida=00, no pronto.
//    Then pulso held high across reset release -> no start until pulso falls and rises again.
//  6 DIGITOS=3, TICKS_CM=2941, pulso 2941*123+1500 cycles, ARREDONDA=1
//    -> medida=12'h124, pronto once.

Source files
------------

// File: rtl/contador_cm_param.sv
// Echo pulse width to distance converter: counts high samples of pulso,
// divides by TICKS_CM into a saturating BCD result with optional half-cm rounding.
module contador_cm_param #(
    parameter int DIGITOS   = 3,
    parameter int TICKS_CM  = 2941,
    parameter int TICK_W    = 12,
    parameter bit ARREDONDA = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pulso,
    output logic [4*DIGITOS-1:0]   medida,
    output logic                   pronto,
    output logic                   ocupado,
    output logic                   overflow,
    output logic [2:0]             db_estado
);

    typedef enum logic [2:0] {
        INICIAL = 3'b000,
        MEDE    = 3'b001,
        ARRED   = 3'b010,
        FIM     = 3'b011
    } estado_t;

    localparam logic [TICK_W-1:0] TICK_ULT = TICK_W'(TICKS_CM - 1);
    localparam logic [TICK_W-1:0] METADE   = TICK_W'(TICKS_CM / 2);

    estado_t                estado_q;
    logic                   pulso_q;
    logic                   armado_q;
    logic [TICK_W-1:0]      tick_q;
    logic [4*DIGITOS-1:0]   bcd_q;
    logic [4*DIGITOS-1:0]   bcd_d;
    logic                   bcd_cheio;
    logic                   carry;
    logic                   overflow_q;
    logic                   pronto_q;
    logic                   ocupado_q;
    logic                   subida;

    // armado_q blocks a pulse that was already high when reset was released.
    assign subida = pulso & ~pulso_q & armado_q;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        bcd_d = bcd_q;
        carry = 1'b1;
        for (int i = 0; i < DIGITOS; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_d[4*i +: 4] = 4'd0;
                end else begin
                    bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
        bcd_cheio = carry;
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            pulso_q    <= 1'b0;
            armado_q   <= 1'b0;
            tick_q     <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            pronto_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            pulso_q <= pulso;
            if (!pulso) begin
                armado_q <= 1'b1;
            end

            case (estado_q)
                INICIAL: begin
                    if (subida) begin
                        estado_q   <= MEDE;
                        bcd_q      <= '0;
                        overflow_q <= 1'b0;
                        tick_q     <= TICK_W'(1);
                        ocupado_q  <= 1'b1;
                    end
                end

                MEDE: begin
                    if (pulso) begin
                        if (tick_q == TICK_ULT) begin
                            tick_q <= '0;
                            if (bcd_cheio) begin
                                overflow_q <= 1'b1;
                            end else begin
                                bcd_q <= bcd_d;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end else if (ARREDONDA) begin
                        estado_q <= ARRED;
                    end else begin
                        estado_q  <= FIM;
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                    end
                end

                ARRED: begin
                    // tick_q now holds the residual of the last partial centimetre.
                    if (tick_q != '0 && tick_q >= METADE) begin
                        if (bcd_cheio) begin
                            overflow_q <= 1'b1;
                        end else begin
                            bcd_q <= bcd_d;
                        end
                    end
                    estado_q  <= FIM;
                    ocupado_q <= 1'b0;
                    pronto_q  <= 1'b1;
                end

                FIM: begin
                    estado_q <= INICIAL;
                    pronto_q <= 1'b0;
                end

                default: begin
                    estado_q  <= INICIAL;
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign medida    = bcd_q;
    assign pronto    = pronto_q;
    assign ocupado   = ocupado_q;
    assign overflow  = overflow_q;
    assign db_estado = estado_q;

endmodule
